// File: rtl/request_acceptor.sv
// Responder side of request/accept/cancel: accept strobe ACCEPT_DELAY cycles after request, then BUSY_CYCLES of busy.
// No backpressure: requests arriving while a transaction is in flight are dropped and flagged as overrun.
module request_acceptor #(
    parameter int ACCEPT_DELAY = 4,
    parameter int BUSY_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        cancel,
    output logic        accept,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic        overrun,
    output logic [15:0] accept_cnt,
    output logic [15:0] drop_cnt
);

    if (ACCEPT_DELAY < 4 || ACCEPT_DELAY > 255) begin : g_bad_accept_delay
        $error("request_acceptor: ACCEPT_DELAY must be in 4..255");
    end
    if (BUSY_CYCLES < 1 || BUSY_CYCLES > 65535) begin : g_bad_busy_cycles
        $error("request_acceptor: BUSY_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACC,
        S_BUSY
    } state_t;

    // WAIT spans ACCEPT_DELAY-1 cycles, so the delay counter tops out at ACCEPT_DELAY-2.
    localparam logic [7:0]  WAIT_LAST = 8'(ACCEPT_DELAY - 2);
    localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  dly_cnt_q;
    logic [15:0] busy_cnt_q;
    logic        accept_q;
    logic        busy_q;
    logic        done_q;
    logic        dropped_q;
    logic        overrun_q;
    logic [15:0] accept_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dly_cnt_q    <= '0;
            busy_cnt_q   <= '0;
            accept_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dropped_q    <= 1'b0;
            overrun_q    <= 1'b0;
            accept_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            accept_q  <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            overrun_q <= request && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (request) begin
                        state_q   <= S_WAIT;
                        dly_cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (cancel) begin
                        state_q    <= S_IDLE;
                        dropped_q  <= 1'b1;
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end else if (dly_cnt_q == WAIT_LAST) begin
                        state_q  <= S_ACC;
                        accept_q <= 1'b1;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 8'd1;
                    end
                end
                S_ACC: begin
                    if (cancel) begin
                        state_q    <= S_IDLE;
                        dropped_q  <= 1'b1;
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end else begin
                        state_q      <= S_BUSY;
                        busy_q       <= 1'b1;
                        busy_cnt_q   <= BUSY_LOAD;
                        done_q       <= (BUSY_LOAD == 16'd0);
                        accept_cnt_q <= accept_cnt_q + 16'd1;
                    end
                end
                S_BUSY: begin
                    // busy_cnt_q counts remaining busy cycles after the current one.
                    if (busy_cnt_q == 16'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_cnt_q <= busy_cnt_q - 16'd1;
                        done_q     <= (busy_cnt_q == 16'd1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign accept     = accept_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dropped    = dropped_q;
    assign overrun    = overrun_q;
    assign accept_cnt = accept_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_request_acceptor.sv
// Bench for request_acceptor: directed scenarios on a default instance, random request/cancel on an ACCEPT_DELAY=6 instance.
module tb_request_acceptor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic request = 1'b0;
    logic cancel = 1'b0;

    logic        acc0, busy0, done0, drop0, ovr0;
    logic [15:0] acnt0, dcnt0;
    logic        acc1, busy1, done1, drop1, ovr1;
    logic [15:0] acnt1, dcnt1;

    request_acceptor #(.ACCEPT_DELAY(4), .BUSY_CYCLES(8)) dut0 (
        .clk(clk), .rst(rst), .request(request), .cancel(cancel),
        .accept(acc0), .busy(busy0), .done(done0), .dropped(drop0), .overrun(ovr0),
        .accept_cnt(acnt0), .drop_cnt(dcnt0)
    );

    request_acceptor #(.ACCEPT_DELAY(6), .BUSY_CYCLES(8)) dut1 (
        .clk(clk), .rst(rst), .request(request), .cancel(cancel),
        .accept(acc1), .busy(busy1), .done(done1), .dropped(drop1), .overrun(ovr1),
        .accept_cnt(acnt1), .drop_cnt(dcnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] pack(input logic a, input logic b, input logic d,
                                         input logic dr, input logic o,
                                         input logic [15:0] ac, input logic [15:0] dc);
        return {a, b, d, dr, o, ac, dc};
    endfunction

    // Reference model: a transaction is described only by its start cycle t0;
    // every output is derived from the offset of the current cycle to t0.
    int          md[2] = '{4, 6};
    int          mb    = 8;
    bit          m_act[2];
    int          m_t0[2];
    logic [15:0] m_acnt[2];
    logic [15:0] m_dcnt[2];
    logic [36:0] m_exp[2];
    int          cyc = 0;
    bit          chk_on = 1'b0;

    task automatic model_step(input int i, input bit r, input bit q, input bit c);
        bit dn;
        bit ov;
        int k;
        int d;
        d  = md[i];
        dn = 1'b0;
        if (r) begin
            m_act[i]  = 1'b0;
            m_acnt[i] = '0;
            m_dcnt[i] = '0;
            m_exp[i]  = '0;
            return;
        end
        ov = q && m_act[i];
        if (!m_act[i]) begin
            if (q) begin
                m_act[i] = 1'b1;
                m_t0[i]  = cyc;
            end
        end else begin
            k = cyc - m_t0[i];
            if (c && k >= 1 && k <= d) begin
                m_act[i]  = 1'b0;
                dn        = 1'b1;
                m_dcnt[i] = m_dcnt[i] + 16'd1;
            end else begin
                if (k == d) m_acnt[i] = m_acnt[i] + 16'd1;
                if (k == d + mb) m_act[i] = 1'b0;
            end
        end
        k = cyc + 1 - m_t0[i];
        m_exp[i] = pack(m_act[i] && k == d, m_act[i] && k > d && k <= d + mb,
                        m_act[i] && k == d + mb, dn, ov, m_acnt[i], m_dcnt[i]);
    endtask

    task automatic tick_check();
        @(negedge clk);
        if (chk_on) begin
            chk("dut0_outputs", 64'(pack(acc0, busy0, done0, drop0, ovr0, acnt0, dcnt0)), 64'(m_exp[0]));
            chk("dut1_outputs", 64'(pack(acc1, busy1, done1, drop1, ovr1, acnt1, dcnt1)), 64'(m_exp[1]));
        end
    endtask

    task automatic drive(input bit r, input bit q, input bit c);
        rst     = r;
        request = q;
        cancel  = c;
        model_step(0, r, q, c);
        model_step(1, r, q, c);
        cyc++;
        if (r) chk_on = 1'b1;
    endtask

    // Observations of the default instance, in scenario-relative cycles.
    int first_acc, last_acc, n_acc, first_drop, first_busy, last_busy, first_done, first_ovr;
    logic [31:0] cnt23;

    task automatic run_scenario(input logic [39:0] rv, input logic [39:0] qv, input logic [39:0] cv);
        first_acc = -1; last_acc = -1; n_acc = 0; first_drop = -1;
        first_busy = -1; last_busy = -1; first_done = -1; first_ovr = -1; cnt23 = '1;
        for (int i = 0; i < 40; i++) begin
            tick_check();
            if (acc0) begin
                if (first_acc < 0) first_acc = i;
                last_acc = i;
                n_acc++;
            end
            if (drop0 && first_drop < 0) first_drop = i;
            if (busy0) begin
                if (first_busy < 0) first_busy = i;
                last_busy = i;
            end
            if (done0 && first_done < 0) first_done = i;
            if (ovr0 && first_ovr < 0) first_ovr = i;
            if (i == 23) cnt23 = {acnt0, dcnt0};
            drive(rv[i], qv[i], cv[i]);
        end
    endtask

    localparam logic [39:0] RST01 = 40'h3;
    localparam logic [39:0] ONE   = 40'h1;

    int started;
    int last_start;
    bit prev_busy1, prev_acc1, prev_can;

    initial begin
        // Nominal
        run_scenario(RST01, ONE << 10, '0);
        chk("nom_accept_at", 64'(first_acc), 64'(14));
        chk("nom_accept_once", 64'(n_acc), 64'(1));
        chk("nom_busy_first", 64'(first_busy), 64'(15));
        chk("nom_busy_last", 64'(last_busy), 64'(22));
        chk("nom_done_at", 64'(first_done), 64'(22));
        chk("nom_cnt_at_23", 64'(cnt23), 64'({16'd1, 16'd0}));

        // Early cancel
        run_scenario(RST01, ONE << 10, ONE << 12);
        chk("early_no_accept", 64'(first_acc), 64'(-1));
        chk("early_dropped_at", 64'(first_drop), 64'(13));
        chk("early_no_busy", 64'(first_busy), 64'(-1));
        chk("early_cnt_at_23", 64'(cnt23), 64'({16'd0, 16'd1}));

        // Cancel on the accept cycle
        run_scenario(RST01, ONE << 10, ONE << 14);
        chk("acccan_accept_at", 64'(first_acc), 64'(14));
        chk("acccan_dropped_at", 64'(first_drop), 64'(15));
        chk("acccan_no_busy", 64'(first_busy), 64'(-1));

        // Overrun, then back-to-back restart
        run_scenario(RST01, (ONE << 10) | (ONE << 18) | (ONE << 23), '0);
        chk("ovr_at", 64'(first_ovr), 64'(19));
        chk("ovr_first_accept", 64'(first_acc), 64'(14));
        chk("ovr_restart_accept", 64'(last_acc), 64'(27));
        chk("ovr_accept_count", 64'(n_acc), 64'(2));

        // Reset mid-busy
        run_scenario(RST01 | (ONE << 17), (ONE << 10) | (ONE << 20), '0);
        chk("rstmid_restart_accept", 64'(last_acc), 64'(24));
        chk("rstmid_done_only_second", 64'(first_done), 64'(32));

        // Random request/cancel, invariants on the ACCEPT_DELAY=6 instance
        for (int i = 0; i < 2; i++) begin
            tick_check();
            drive(1'b1, 1'b0, 1'b0);
        end
        started = 0; last_start = -100;
        prev_busy1 = 1'b0; prev_acc1 = 1'b0; prev_can = 1'b0;
        for (int i = 0; i < 3040; i++) begin
            bit q, c;
            tick_check();
            if (busy1 && !prev_busy1)
                chk("busy_rise_after_acc", 64'({prev_acc1, prev_can}), 64'(2'b10));
            if (acc1)
                chk("accept_latency", 64'(cyc - last_start), 64'(6));
            q = (i < 3000) && ($urandom_range(0, 5) == 0);
            c = (i < 3000) && ($urandom_range(0, 9) == 0);
            if (!m_act[1] && q) begin
                started++;
                last_start = cyc;
            end
            prev_busy1 = busy1;
            prev_acc1  = acc1;
            prev_can   = c;
            drive(1'b0, q, c);
        end
        tick_check();
        chk("served_count", 64'(int'(acnt1) + int'(dcnt1)), 64'(started));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
